ring_link_arbiter: RTL and testbench



---
 rtl/ring_link_arbiter_pkg.sv | 13 +
 rtl/ring_link_arbiter_fifo.sv | 70 +++++++
 rtl/ring_link_arbiter.sv | 95 +++++++++
 tb/tb_ring_link_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_link_arbiter_pkg.sv
// rtl/ring_link_arbiter_pkg.sv - shared ring link beat type and link arbiter defaults
//
// Purpose: ring beat type plus the burst and FIFO defaults shared by both
//          link directions (left, right) of a cluster's ring router.
// Ports:   none (package).
package ring_link_arbiter_pkg;

  typedef logic [7:0] remote_data_t;

  localparam int unsigned RingMaxFwdBurst   = 4;
  localparam int unsigned RingLinkFifoDepth = 2;

endpackage

// File: rtl/ring_link_arbiter_fifo.sv
// rtl/ring_link_arbiter_fifo.sv - registered (non fall-through) FIFO for the ring link output
//
// Purpose: circular-buffer FIFO. A pushed beat becomes visible on data_o the
//          cycle after the push, which cuts the link combinationally.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   flush_i          synchronous clear of all entries
//   push_i, data_i   write request and beat (ignored when full)
//   pop_i            read request (ignored when empty)
//   data_o           head entry
//   full_o, empty_o  occupancy flags
module ring_link_arbiter_fifo #(
  parameter int unsigned Depth  = 2,
  parameter type         data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  flush_i,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  data_t           mem [Depth];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;
  logic [CntW-1:0] count;
  logic            do_push;
  logic            do_pop;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // Cleared storage keeps the head at zero while reset is held.
      for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CntW'(1);
      else if (do_pop && !do_push) count <= count - CntW'(1);
    end
  end

endmodule

// File: rtl/ring_link_arbiter.sv
// rtl/ring_link_arbiter.sv - forwarded-priority ring link arbiter with anti-starvation burst limit
//
// Purpose: merges forwarded ring traffic and local slide-unit traffic onto one
//          outgoing ring link. Forwarded wins, but after MaxFwdBurst forwarded
//          grants with local waiting, local is forced through.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   fwd_i, fwd_valid_i, fwd_ready_o   forwarded beat stream from neighbour router
//   loc_i, loc_valid_i, loc_ready_o   local beat stream from the slide unit
//   link_o, link_valid_o, link_ready_i  outgoing link to neighbour router
//   loc_starved_o                     pulse when local won only by the burst limit
module ring_link_arbiter
  import ring_link_arbiter_pkg::*;
#(
  parameter type         data_t      = remote_data_t,
  parameter int unsigned MaxFwdBurst = RingMaxFwdBurst,
  parameter int unsigned FifoDepth   = RingLinkFifoDepth
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  data_t fwd_i,
  input  logic  fwd_valid_i,
  output logic  fwd_ready_o,
  input  data_t loc_i,
  input  logic  loc_valid_i,
  output logic  loc_ready_o,
  output data_t link_o,
  output logic  link_valid_o,
  input  logic  link_ready_i,
  output logic  loc_starved_o
);

  localparam int unsigned CntW = $clog2(MaxFwdBurst + 1);

  if (MaxFwdBurst < 1 || MaxFwdBurst > 15) begin : g_bad_burst
    $error("ring_link_arbiter: MaxFwdBurst must be in 1..15");
  end
  if (FifoDepth < 2) begin : g_bad_depth
    $error("ring_link_arbiter: FifoDepth must be at least 2");
  end

  logic [CntW-1:0] cnt;
  logic            full;
  logic            empty;
  logic            force_loc;
  logic            fwd_acc;
  logic            loc_acc;
  data_t           push_data;

  assign force_loc   = loc_valid_i && (cnt == CntW'(MaxFwdBurst));
  // Readies look at input valids only, never at link_ready_i, so no
  // combinational path runs around the ring.
  assign fwd_ready_o = !full && !force_loc;
  assign loc_ready_o = !full && (!fwd_valid_i || force_loc);

  assign fwd_acc       = fwd_valid_i && fwd_ready_o;
  assign loc_acc       = loc_valid_i && loc_ready_o;
  assign push_data     = loc_acc ? loc_i : fwd_i;
  assign loc_starved_o = loc_acc && force_loc && fwd_valid_i;
  assign link_valid_o  = !empty;

  // cnt counts forwarded grants taken while local is waiting; any local grant
  // or a withdrawn local request starts a fresh burst.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (loc_acc || !loc_valid_i) begin
      cnt <= '0;
    end else if (fwd_acc && (cnt != CntW'(MaxFwdBurst))) begin
      cnt <= cnt + CntW'(1);
    end
  end

  ring_link_arbiter_fifo #(
    .Depth  (FifoDepth),
    .data_t (data_t)
  ) i_link_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (fwd_acc || loc_acc),
    .data_i  (push_data),
    .pop_i   (link_ready_i),
    .data_o  (link_o),
    .full_o  (full),
    .empty_o (empty)
  );

  a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(fwd_valid_i && loc_valid_i && fwd_ready_o && loc_ready_o));

  a_link_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (link_valid_o && !link_ready_i) |=> $stable(link_o));

endmodule

// File: tb/tb_ring_link_arbiter.sv
// tb/tb_ring_link_arbiter.sv - self-checking bench for ring_link_arbiter
module tb_ring_link_arbiter;
  import ring_link_arbiter_pkg::*;

  localparam int MAXB  = RingMaxFwdBurst;
  localparam int DEPTH = RingLinkFifoDepth;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  remote_data_t fwd_i = '0;
  logic         fwd_valid_i = 1'b0;
  logic         fwd_ready_o;
  remote_data_t loc_i = '0;
  logic         loc_valid_i = 1'b0;
  logic         loc_ready_o;
  remote_data_t link_o;
  logic         link_valid_o;
  logic         link_ready_i = 1'b1;
  logic         loc_starved_o;

  always #5 clk_i = ~clk_i;

  ring_link_arbiter dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fwd_i         (fwd_i),
    .fwd_valid_i   (fwd_valid_i),
    .fwd_ready_o   (fwd_ready_o),
    .loc_i         (loc_i),
    .loc_valid_i   (loc_valid_i),
    .loc_ready_o   (loc_ready_o),
    .link_o        (link_o),
    .link_valid_o  (link_valid_o),
    .link_ready_i  (link_ready_i),
    .loc_starved_o (loc_starved_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: pending beats per source, link queue, and how many
  // forwarded grants local has sat through.
  remote_data_t fwd_src[$];
  remote_data_t loc_src[$];
  remote_data_t link_q[$];
  int           waited = 0;
  int           dut_order[$];
  int           starve_cnt = 0;
  bit           rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    fwd_valid_i = (fwd_src.size() != 0);
    fwd_i       = fwd_valid_i ? fwd_src[0] : '0;
    loc_valid_i = (loc_src.size() != 0);
    loc_i       = loc_valid_i ? loc_src[0] : '0;
  endtask

  task automatic cycle();
    bit room, must_loc, e_fr, e_lr, fa, la;
    @(negedge clk_i);
    room     = (link_q.size() < DEPTH);
    must_loc = loc_valid_i && (waited >= MAXB);
    e_fr     = room && !must_loc;
    e_lr     = room && (!fwd_valid_i || must_loc);
    fa       = fwd_valid_i && e_fr;
    la       = loc_valid_i && e_lr;
    check("fwd_ready", fwd_ready_o, e_fr);
    check("loc_ready", loc_ready_o, e_lr);
    check("link_valid", link_valid_o, link_q.size() != 0);
    if (link_q.size() != 0) check("link_data", link_o, link_q[0]);
    check("loc_starved", loc_starved_o, la && must_loc && fwd_valid_i);
    if (fwd_valid_i && fwd_ready_o) dut_order.push_back(0);
    if (loc_valid_i && loc_ready_o) dut_order.push_back(1);
    if (loc_starved_o) starve_cnt++;
    @(posedge clk_i);
    if (link_q.size() != 0 && link_ready_i) void'(link_q.pop_front());
    if (fa) link_q.push_back(fwd_src.pop_front());
    if (la) link_q.push_back(loc_src.pop_front());
    if (la || !loc_valid_i) waited = 0;
    else if (fa) waited = (waited < MAXB) ? waited + 1 : MAXB;
    #1;
    if (rand_mode) begin
      if ($urandom_range(0, 2) == 0 && fwd_src.size() < 3) fwd_src.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0 && loc_src.size() < 3) loc_src.push_back(8'($urandom));
      link_ready_i = ($urandom_range(0, 3) != 0);
    end
    drive();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (fwd_src.size() != 0 || loc_src.size() != 0 || link_q.size() != 0); i++)
      cycle();
    check("drain_done", fwd_src.size() + loc_src.size() + link_q.size(), 0);
  endtask

  initial begin
    // Reset with idle inputs.
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_link_valid", link_valid_o, 1'b0);
    check("rst_link_data", link_o, 8'h00);
    check("rst_fwd_ready", fwd_ready_o, 1'b1);
    check("rst_loc_ready", loc_ready_o, 1'b1);
    check("rst_starved", loc_starved_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Single local beat: visible exactly one cycle after accept.
    loc_src.push_back(8'hA5);
    drive();
    cycle();
    check("a5_valid", link_valid_o, 1'b1);
    check("a5_data", link_o, 8'hA5);
    drain();

    // Forwarded streaming 1..10, no bubbles (model tracks link_valid each cycle).
    for (int i = 1; i <= 10; i++) fwd_src.push_back(8'(i));
    drive();
    drain();

    // Starvation pattern F,F,F,F,L repeated.
    for (int i = 0; i < 20; i++) fwd_src.push_back(8'(8'h40 + i));
    for (int i = 0; i < 3; i++) loc_src.push_back(8'(8'hC0 + i));
    drive();
    dut_order.delete();
    starve_cnt = 0;
    repeat (15) cycle();
    for (int i = 0; i < 15; i++)
      check($sformatf("starve_order_%0d", i), (i < dut_order.size()) ? dut_order[i] : 9, (i % 5 == 4) ? 1 : 0);
    check("starve_pulses", starve_cnt, 3);
    drain();

    // Backpressure: FIFO fills after DEPTH accepts, then both readies drop.
    link_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) fwd_src.push_back(8'(8'h10 + i));
    drive();
    repeat (DEPTH) cycle();
    check("bp_fwd_ready", fwd_ready_o, 1'b0);
    check("bp_loc_ready", loc_ready_o, 1'b0);
    check("bp_pending", fwd_src.size(), 5 - DEPTH);
    repeat (3) cycle();
    link_ready_i = 1'b1;
    drain();

    // Local withdraw after 2 forwarded grants restarts the burst count.
    for (int i = 0; i < 12; i++) fwd_src.push_back(8'(8'h60 + i));
    loc_src.push_back(8'h55);
    drive();
    repeat (2) cycle();
    loc_src.delete();
    drive();
    cycle();
    dut_order.delete();
    loc_src.push_back(8'h77);
    drive();
    repeat (5) cycle();
    for (int i = 0; i < 5; i++)
      check($sformatf("withdraw_order_%0d", i), (i < dut_order.size()) ? dut_order[i] : 9, (i == 4) ? 1 : 0);
    drain();

    // Reset mid-operation with two beats buffered.
    link_ready_i = 1'b0;
    fwd_src.push_back(8'h91);
    fwd_src.push_back(8'h92);
    drive();
    repeat (2) cycle();
    #2;
    rst_ni = 1'b0;
    fwd_src.delete();
    loc_src.delete();
    link_q.delete();
    waited = 0;
    drive();
    #1;
    check("midrst_link_valid", link_valid_o, 1'b0);
    check("midrst_fwd_ready", fwd_ready_o, 1'b1);
    check("midrst_link_data", link_o, 8'h00);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    link_ready_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (2) cycle();
    // cnt restarts at zero: local waits a full burst.
    for (int i = 0; i < 8; i++) fwd_src.push_back(8'(8'hB0 + i));
    loc_src.push_back(8'h3C);
    drive();
    dut_order.delete();
    repeat (5) cycle();
    for (int i = 0; i < 5; i++)
      check($sformatf("postrst_order_%0d", i), (i < dut_order.size()) ? dut_order[i] : 9, (i == 4) ? 1 : 0);
    drain();

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    repeat (400) cycle();
    rand_mode = 1'b0;
    link_ready_i = 1'b1;
    drive();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
